// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO read port and streaming output bundle for fifo_stream_reader
interface fifo_stream_reader_if #(
  parameter int FIFO_WIDTH = 16
);

  // FIFO read side
  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_underflow;

  // Streaming output side
  logic                  m_valid;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_ready;

  // The reader: issues reads, sources the output stream
  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_data_out,
    input  fifo_underflow,
    output m_valid,
    output m_data,
    input  m_ready
  );

  // The environment: the FIFO plus the downstream consumer
  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_data_out,
    output fifo_underflow,
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side consumer presenting words on a valid/ready stream
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  fifo_stream_reader_if.master bus,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_word_count,
  output logic                 o_err_underflow
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  // Two-entry output buffer, FIFO ordered: r_head points at the oldest word
  logic [FIFO_WIDTH-1:0] r_buf [0:1];
  logic                  r_head;
  logic [1:0]            r_occ;
  logic                  r_inflight;

  logic [CNT_WIDTH-1:0]  r_word_count;
  logic                  r_err_underflow;

  logic                  w_pop;
  logic                  w_capture;
  logic                  w_rd_en;
  logic                  w_tail;
  logic [2:0]            w_load;

  // A word leaves whenever something is held and downstream takes it
  assign w_pop     = (r_occ != 2'd0) && bus.m_ready;
  // Read data is always present the cycle after our own read request
  assign w_capture = r_inflight;
  // Slots committed after this edge if no new read is issued
  assign w_load    = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  // Next free slot; never used while the buffer is full
  assign w_tail    = r_head ^ r_occ[0];

  // Next-state and read-issue decode
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        w_rd_en = i_enable && !bus.fifo_empty && (w_load < 3'd2);
        if (!i_enable) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_enable) begin
          w_state_nxt = ST_STREAM;
        end else if ((r_occ == 2'd0) && !r_inflight) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Buffer, occupancy and in-flight tracking; reset drops any read in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_head     <= 1'b0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_capture) begin
        r_buf[w_tail] <= bus.fifo_data_out;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_occ <= r_occ + {1'b0, w_capture} - {1'b0, w_pop};
    end
  end

  // Delivered-word counter (wraps silently) and sticky underflow flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word_count    <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_word_count <= r_word_count + 1'b1;
      end
      if (r_inflight && bus.fifo_underflow) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

  assign bus.fifo_rd_en  = w_rd_en;
  assign bus.m_valid     = (r_occ != 2'd0);
  assign bus.m_data      = r_buf[r_head];
  assign o_busy          = (r_state != ST_IDLE);
  assign o_word_count    = r_word_count;
  assign o_err_underflow = r_err_underflow;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          busy;
  logic [CW-1:0] word_count;
  logic          err;

  fifo_stream_reader_if #(.FIFO_WIDTH(W)) bus ();

  fifo_stream_reader #(
    .FIFO_WIDTH(W),
    .CNT_WIDTH (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (enable),
    .bus            (bus),
    .o_busy         (busy),
    .o_word_count   (word_count),
    .o_err_underflow(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words still in the FIFO, words read but not yet delivered
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int           model_cnt;
  int           outstanding;
  int           cyc;
  bit           last_rd;
  bit           last_pop;
  bit           prev_stall;
  logic [W-1:0] prev_data;
  int           rd_cycles[$];
  int           pop_cycles[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, then play the FIFO after the rising edge
  task automatic step();
    logic [W-1:0] w;
    @(negedge clk);
    last_rd  = bus.fifo_rd_en;
    last_pop = bus.m_valid && bus.m_ready;
    check("rd_while_empty", 32'(last_rd && bus.fifo_empty), 32'd0);
    check("rd_while_disabled", 32'(last_rd && !enable), 32'd0);
    check("outstanding_le_2", 32'(outstanding <= 2), 32'd1);
    check("word_count", 32'(word_count), 32'(model_cnt % 16));
    if (prev_stall) begin
      check("hold_valid", 32'(bus.m_valid), 32'd1);
      check("hold_data", 32'(bus.m_data), 32'(prev_data));
    end
    if (last_pop) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", 32'(bus.m_data), 32'hDEAD_BEEF);
      end else begin
        w = exp_q.pop_front();
        check("m_data_order", 32'(bus.m_data), 32'(w));
      end
      pop_cycles.push_back(cyc);
    end
    if (last_rd) rd_cycles.push_back(cyc);
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_data  = bus.m_data;
    @(posedge clk);
    #1;
    cyc++;
    if (last_rd && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      exp_q.push_back(w);
      outstanding++;
      bus.fifo_data_out = w;
    end else begin
      bus.fifo_data_out = W'($urandom);
    end
    if (last_pop) begin
      model_cnt++;
      outstanding--;
    end
    bus.fifo_underflow = 1'b0;
    bus.fifo_empty     = (fifo_q.size() == 0);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    exp_q.delete();
    outstanding        = 0;
    model_cnt          = 0;
    prev_stall         = 1'b0;
    bus.fifo_data_out  = W'($urandom);
    bus.fifo_underflow = 1'b0;
    bus.fifo_empty     = (fifo_q.size() == 0);
  endtask

  task automatic wait_read(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (last_rd) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc                = 0;
    rst                = 1'b1;
    enable             = 1'b0;
    bus.m_ready        = 1'b0;
    bus.fifo_empty     = 1'b1;
    bus.fifo_data_out  = '0;
    bus.fifo_underflow = 1'b0;
    do_reset();

    // Reset state
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);

    // Stream 8 preloaded words with the consumer always ready
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    rd_cycles.delete();
    pop_cycles.delete();
    bus.m_ready = 1'b1;
    enable      = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("t1_delivered", 32'(pop_cycles.size()), 32'd8);
    if (pop_cycles.size() >= 8 && rd_cycles.size() > 0) begin
      check("t1_back_to_back", 32'(pop_cycles[7] - pop_cycles[0]), 32'd7);
      check("t1_first_latency", 32'(pop_cycles[0] - rd_cycles[0]), 32'd2);
    end else begin
      check("t1_timing_data", 32'd0, 32'd1);
    end
    check("t1_word_count", 32'(word_count), 32'd8);
    check("t1_err", 32'(err), 32'd0);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("t1_idle_busy", 32'(busy), 32'd0);

    // Backpressure: ready pattern 1,0,0,1
    do_reset();
    for (int i = 0; i < 4; i++) push_word(W'(16'hA0 + i));
    enable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bus.m_ready = ((i % 4) == 0) || ((i % 4) == 3);
      step();
    end
    check("t2_delivered", 32'(model_cnt), 32'd4);
    check("t2_nothing_left", 32'(exp_q.size() + fifo_q.size()), 32'd0);

    // Disable right after the read of 0x55
    do_reset();
    push_word(W'(16'h55));
    push_word(W'(16'h66));
    bus.m_ready = 1'b1;
    enable      = 1'b1;
    wait_read("t3_read_seen");
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (outstanding > 0) check("t3_busy_while_held", 32'(busy), 32'd1);
      step();
    end
    check("t3_delivered_55", 32'(model_cnt), 32'd1);
    check("t3_no_more_reads", 32'(fifo_q.size()), 32'd1);
    check("t3_busy_dropped", 32'(busy), 32'd0);
    fifo_q.delete();

    // Reset the cycle after a read; the in-flight word must be discarded
    do_reset();
    push_word(W'(16'h11));
    push_word(W'(16'h22));
    bus.m_ready = 1'b1;
    enable      = 1'b1;
    wait_read("t4_read_seen");
    do_reset();
    check("t4_m_valid", 32'(bus.m_valid), 32'd0);
    check("t4_word_count", 32'(word_count), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) step();
    check("t4_m_valid_later", 32'(bus.m_valid), 32'd0);
    fifo_q.delete();
    bus.fifo_empty = 1'b1;

    // Counter wrap with a 4-bit counter after 17 words
    do_reset();
    for (int i = 0; i < 17; i++) push_word(W'($urandom));
    enable = 1'b1;
    for (int i = 0; i < 300 && model_cnt < 17; i++) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      step();
    end
    check("t5_delivered", 32'(model_cnt), 32'd17);
    step();
    check("t5_wrap", 32'(word_count), 32'd1);

    // Underflow with nothing in flight is ignored
    do_reset();
    bus.fifo_underflow = 1'b1;
    step();
    step();
    check("t6_no_err_idle", 32'(err), 32'd0);

    // Injected underflow the cycle after a read: sticky until reset
    push_word(W'(16'h77));
    push_word(W'(16'h88));
    bus.m_ready = 1'b1;
    enable      = 1'b1;
    wait_read("t6_read_seen");
    bus.fifo_underflow = 1'b1;
    step();
    check("t6_err_set", 32'(err), 32'd1);
    for (int i = 0; i < 5; i++) step();
    check("t6_err_sticky", 32'(err), 32'd1);
    do_reset();
    check("t6_err_cleared", 32'(err), 32'd0);
    fifo_q.delete();
    bus.fifo_empty = 1'b1;

    // Random traffic: enable, ready and FIFO fill all randomised
    do_reset();
    for (int i = 0; i < 800; i++) begin
      enable      = ($urandom_range(0, 15) != 0);
      bus.m_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1 && fifo_q.size() < 16) push_word(W'($urandom));
      step();
    end
    enable      = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("t7_all_delivered", 32'(exp_q.size()), 32'd0);
    check("t7_busy_end", 32'(busy), 32'd0);
    check("t7_err_end", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side consumer for the team's synchronous FIFO.
- Pulls words from the FIFO read port (rd_en / data_out / empty) and presents them on a valid/ready streaming output.
- Absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, so throughput is one word per clock with no underflow and no lost words.
- Sits between the FIFO and any downstream consumer; also usable as the synthesizable drain side in FIFO system benches.

Parameters:
- FIFO_WIDTH, 16, width of FIFO data_out and of m_data.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  1 = fetch from FIFO; 0 = stop fetching and drain what is held.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data_out  input  FIFO_WIDTH  FIFO read data, valid the cycle after a read.
- fifo_underflow  input  1  FIFO underflow flag (read attempted while empty).
- fifo_rd_en  output  1  read request to FIFO.
- m_valid  output  1  output word available.
- m_data  output  FIFO_WIDTH  output word.
- m_ready  input  1  downstream accepts the word when m_valid && m_ready.
- busy  output  1  state != IDLE.
- word_count  output  CNT_WIDTH  number of words delivered on m_*.
- err_underflow  output  1  sticky; set if fifo_underflow is seen the cycle after own fifo_rd_en.

Behaviour:
- Reset (rst=1 at clk edge) clears everything:
  - fifo_rd_en=0, m_valid=0, m_data=0, busy=0, word_count=0, err_underflow=0.
  - Buffer occupancy=0, inflight=0, state=IDLE.
  - A read in flight when reset is applied is discarded: its data is not captured the following cycle.
- Terms:
  - inflight: 1-bit register, set the cycle after fifo_rd_en=1.
  - occ: buffer occupancy, 0..2.
  - pop: m_valid && m_ready.
- Read issue (combinational):
  - fifo_rd_en = (state==STREAM) && enable && !fifo_empty && (occ + inflight - pop < 2).
  - fifo_rd_en is never asserted while fifo_empty=1, so the FIFO must never flag underflow.
- Capture:
  - When inflight=1, fifo_data_out is written into the buffer tail on that edge.
  - Buffer is FIFO-ordered; words leave on m_* in exactly the order read.
- Output:
  - m_valid = (occ != 0); m_data = buffer head.
  - While m_valid=1 and m_ready=0, m_data and m_valid hold stable.
  - On pop, head advances.
  - Simultaneous capture and pop in one cycle: occ unchanged, order preserved.
- Throughput: with m_ready held 1 and FIFO non-empty, one word per cycle after a 2-cycle startup. First m_valid comes 2 cycles after the first fifo_rd_en edge:
  - cycle N: rd_en;
  - cycle N+1: data captured;
  - cycle N+1 after the edge: m_valid.
- State machine:
  - IDLE -> STREAM when enable=1.
  - STREAM -> DRAIN when enable=0.
  - DRAIN -> IDLE when occ==0 && inflight==0.
  - DRAIN -> STREAM when enable=1.
  - DRAIN issues no reads but keeps delivering buffered and in-flight words.
- word_count increments by 1 on each pop and wraps modulo 2^CNT_WIDTH with no flag.
- err_underflow is set when inflight && fifo_underflow and stays set until rst. This indicates a FIFO or protocol fault.
- Boundary cases:
  - FIFO goes empty mid-stream: reads stop the same cycle; m_valid drops after the buffer empties.
  - Backpressure with the buffer full: no reads are issued and no word is dropped.

Test Plan:
- Reset then stream: FIFO preloaded with 8 words 0x0001..0x0008, enable=1, m_ready=1
  -> 8 words out in order on 8 consecutive cycles; word_count=8; fifo_rd_en never asserted while fifo_empty=1; err_underflow=0.
- Backpressure: 4 words 0xA0..0xA3, m_ready toggling 1,0,0,1,...
  -> occ never exceeds 2; m_data held stable while stalled; all 4 delivered in order.
- Disable mid-stream: deassert enable right after a read of 0x55
  -> state enters DRAIN; 0x55 still delivered; busy falls only after occ=0; no further reads.
- Reset with a read in flight: rst=1 the cycle after fifo_rd_en
  -> in-flight word not captured; m_valid=0, word_count=0, busy=0 the next cycle.
- Counter wrap: CNT_WIDTH=4, stream 17 words
  -> word_count reads 1 after the 17th pop.
- Injected fault: force fifo_underflow=1 the cycle after a read
  -> err_underflow=1 and stays 1 until rst.
